// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: shares one main-memory port between two cache controllers.
// Whole transactions are serialised. The winning command is registered at grant.
// ready/rdata are routed back only to the granted requester.
// Build option: define MAIN_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins);
// otherwise arbitration is round-robin on the last requester served.
module main_mem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ready0,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ready1,
  output logic [DATA_W-1:0] rdata,
  output logic              gnt0,
  output logic              gnt1,
  output logic              main_read,
  output logic              main_write,
  output logic [ADDR_W-1:0] main_addr,
  output logic [DATA_W-1:0] main_wdata,
  input  logic              main_ready,
  input  logic [DATA_W-1:0] main_rdata
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              op_q, op_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              main_read_q, main_read_d;
  logic              main_write_q, main_write_d;
  logic [ADDR_W-1:0] main_addr_q, main_addr_d;
  logic [DATA_W-1:0] main_wdata_q, main_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic pend0, pend1, pick0, read_done;

  // Request decode and arbitration choice for the IDLE cycle.
  always_comb begin
    pend0 = rd0 | wr0;
    pend1 = rd1 | wr1;
`ifdef MAIN_ARB_FIXED_PRIO_EN
    pick0 = pend0;
`else
    pick0 = pend0 & (~pend1 | last_q);
`endif
  end

  // Next-state, command capture and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    op_d         = op_q;
    main_addr_d  = main_addr_q;
    main_wdata_d = main_wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick0) begin
          state_d     = GNT0;
          last_d      = 1'b0;
          op_d        = wr0 & ~rd0;
          main_addr_d = addr0;
          if (wr0 & ~rd0) main_wdata_d = wdata0;
        end else if (pend1) begin
          state_d     = GNT1;
          last_d      = 1'b1;
          op_d        = wr1 & ~rd1;
          main_addr_d = addr1;
          if (wr1 & ~rd1) main_wdata_d = wdata1;
        end
      end
      GNT0, GNT1: begin
        if (main_ready) begin
          state_d = IDLE;
          if (!op_q) rdata_d = main_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt0_d       = (state_d == GNT0);
    gnt1_d       = (state_d == GNT1);
    main_read_d  = (state_d != IDLE) & ~op_d;
    main_write_d = (state_d != IDLE) & op_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      op_q         <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      main_read_q  <= 1'b0;
      main_write_q <= 1'b0;
      main_addr_q  <= '0;
      main_wdata_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      op_q         <= op_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      main_read_q  <= main_read_d;
      main_write_q <= main_write_d;
      main_addr_q  <= main_addr_d;
      main_wdata_q <= main_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Completion returns combinationally to the granted requester only.
  always_comb begin
    read_done = main_ready & main_read_q;
    ready0    = main_ready & gnt0_q;
    ready1    = main_ready & gnt1_q;
    rdata     = read_done ? main_rdata : rdata_q;
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign main_read  = main_read_q;
  assign main_write = main_write_q;
  assign main_addr  = main_addr_q;
  assign main_wdata = main_wdata_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed self-checking bench for main_mem_arbiter.
// Honours MAIN_ARB_FIXED_PRIO_EN for the expected contention grant order.
module tb_main_mem_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              rd0, wr0, rd1, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ready0, ready1;
  logic [DATA_W-1:0] rdata;
  logic              gnt0, gnt1;
  logic              main_read, main_write;
  logic [ADDR_W-1:0] main_addr;
  logic [DATA_W-1:0] main_wdata;
  logic              main_ready;
  logic [DATA_W-1:0] main_rdata;

  int errors = 0;
  int checks = 0;
  logic exp_gnt1 [4];

  main_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ready0(ready0),
    .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ready1(ready1),
    .rdata(rdata), .gnt0(gnt0), .gnt1(gnt1),
    .main_read(main_read), .main_write(main_write),
    .main_addr(main_addr), .main_wdata(main_wdata),
    .main_ready(main_ready), .main_rdata(main_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
`ifdef MAIN_ARB_FIXED_PRIO_EN
    exp_gnt1 = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_gnt1 = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    reset = 1'b1;
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    main_ready = 0; main_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_main_read", main_read, 0);
    chk("rst_main_write", main_write, 0);
    chk("rst_main_addr", main_addr, 0);
    chk("rst_main_wdata", main_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ready0", ready0, 0);
    chk("rst_ready1", ready1, 0);

    // Single read, memory answers in the 3rd strobe cycle.
    rd0 = 1; addr0 = 10'h12A;
    tick();
    chk("rd_c1_read", main_read, 1);
    chk("rd_c1_write", main_write, 0);
    chk("rd_c1_gnt0", gnt0, 1);
    chk("rd_c1_addr", main_addr, 10'h12A);
    chk("rd_c1_ready0", ready0, 0);
    tick();
    chk("rd_c2_read", main_read, 1);
    chk("rd_c2_ready0", ready0, 0);
    tick();
    chk("rd_c3_read", main_read, 1);
    main_ready = 1; main_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_ready0", ready0, 1);
    chk("rd_ready1", ready1, 0);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    rd0 = 0;
    tick();
    main_ready = 0; main_rdata = 32'h0;
    #1;
    chk("rd_end_read", main_read, 0);
    chk("rd_end_gnt0", gnt0, 0);
    chk("rd_end_ready0", ready0, 0);
    chk("rd_hold_rdata", rdata, 32'hDEADBEEF);

    // Single write from requester 1.
    wr1 = 1; addr1 = 10'h3FF; wdata1 = 32'hA5A5A5A5;
    tick();
    chk("wr_write", main_write, 1);
    chk("wr_read", main_read, 0);
    chk("wr_gnt1", gnt1, 1);
    chk("wr_addr", main_addr, 10'h3FF);
    chk("wr_wdata", main_wdata, 32'hA5A5A5A5);
    main_ready = 1; main_rdata = 32'h12345678;
    #1;
    chk("wr_ready1", ready1, 1);
    chk("wr_ready0", ready0, 0);
    chk("wr_rdata_kept", rdata, 32'hDEADBEEF);
    wr1 = 0;
    tick();
    main_ready = 0;
    #1;
    chk("wr_end_write", main_write, 0);
    chk("wr_end_gnt1", gnt1, 0);

    // Contention: rd0 and wr1 held continuously, single-cycle memory.
    rd0 = 1; addr0 = 10'h055; wr1 = 1; addr1 = 10'h066; wdata1 = 32'h7;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("cont%0d_gnt1", i), gnt1, exp_gnt1[i]);
      chk($sformatf("cont%0d_gnt0", i), gnt0, !exp_gnt1[i]);
      chk($sformatf("cont%0d_write", i), main_write, exp_gnt1[i]);
      chk($sformatf("cont%0d_addr", i), main_addr, exp_gnt1[i] ? 64'h066 : 64'h055);
      main_ready = 1;
      #1;
      chk($sformatf("cont%0d_ready1", i), ready1, exp_gnt1[i]);
      chk($sformatf("cont%0d_ready0", i), ready0, !exp_gnt1[i]);
      if (i == 3) begin rd0 = 0; wr1 = 0; end
      tick();
      main_ready = 0;
      #1;
      chk($sformatf("cont%0d_idle", i), {gnt0, gnt1}, 0);
    end

    // Address stability while granted.
    rd0 = 1; addr0 = 10'h010;
    tick();
    chk("stab_addr_a", main_addr, 10'h010);
    addr0 = 10'h020; addr1 = 10'h111; wdata0 = 32'hFFFF0000;
    tick();
    chk("stab_addr_b", main_addr, 10'h010);
    chk("stab_gnt0", gnt0, 1);
    tick();
    chk("stab_addr_c", main_addr, 10'h010);
    main_ready = 1; main_rdata = 32'h0000CAFE; rd0 = 0;
    #1;
    chk("stab_ready0", ready0, 1);
    tick();
    main_ready = 0;
    #1;
    chk("stab_idle", gnt0, 0);

    // Reset during the 2nd cycle of a GNT1 read.
    rd1 = 1; addr1 = 10'h0AB;
    tick();
    chk("rstm_gnt1", gnt1, 1);
    chk("rstm_read", main_read, 1);
    tick();
    reset = 1; rd1 = 0;
    tick();
    reset = 0;
    #1;
    chk("rstm_read_drop", main_read, 0);
    chk("rstm_gnt1_drop", gnt1, 0);
    main_ready = 1; main_rdata = 32'h00000BAD;
    #1;
    chk("rstm_late_ready1", ready1, 0);
    chk("rstm_late_ready0", ready0, 0);
    chk("rstm_rdata", rdata, 0);
    tick();
    main_ready = 0;
    rd0 = 1; rd1 = 1; addr0 = 10'h200; addr1 = 10'h201;
    tick();
    chk("rstm_next_gnt0", gnt0, 1);
    chk("rstm_next_gnt1", gnt1, 0);
    main_ready = 1; main_rdata = 32'h01020304; rd0 = 0; rd1 = 0;
    #1;
    chk("rstm_next_rdata", rdata, 32'h01020304);
    tick();
    main_ready = 0;

    // Both strobes from one requester: read wins, write data not captured.
    rd0 = 1; wr0 = 1; wdata0 = 32'h1; addr0 = 10'h077;
    tick();
    chk("both_read", main_read, 1);
    chk("both_write", main_write, 0);
    chk("both_wdata", main_wdata, 0);
    main_ready = 1; main_rdata = 32'h55AA55AA; rd0 = 0; wr0 = 0;
    #1;
    chk("both_rdata", rdata, 32'h55AA55AA);
    tick();
    main_ready = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
